// File: rtl/alu_sched.sv
// alu_sched: round-robin scheduler sharing one multi-cycle ALU among N_REQ requesters,
// with local divide-by-zero rejection and a watchdog on the ALU completion pulse.
module alu_sched #(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 40
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [2*N_REQ-1:0]   req_mode,
    input  logic [32*N_REQ-1:0]  req_a,
    input  logic [32*N_REQ-1:0]  req_b,
    output logic [N_REQ-1:0]     req_ack,
    output logic [N_REQ-1:0]     rsp_valid,
    output logic [63:0]          rsp_data,
    output logic                 rsp_err,
    output logic                 busy,
    output logic                 alu_valid,
    output logic [1:0]           alu_mode,
    output logic [31:0]          alu_a,
    output logic [31:0]          alu_b,
    input  logic                 alu_ready,
    input  logic [63:0]          alu_out
);
    localparam int IW = $clog2(N_REQ);
    localparam int WW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t         state, state_nx;
    logic [IW-1:0]  ptr, g, gsel, j;
    logic           any, err, dz, tmo;
    logic [WW-1:0]  wd;
    logic [1:0]     sel_mode;
    logic [31:0]    sel_a, sel_b;
    logic [N_REQ-1:0] g_oh;

    // Scan downward so the last hit is the first requester at or after ptr.
    always_comb begin
        gsel = '0;
        any  = 1'b0;
        j    = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            j = IW'((int'(ptr) + i) % N_REQ);
            if (req_valid[j]) begin
                gsel = j;
                any  = 1'b1;
            end
        end
    end

    always_comb begin
        sel_mode = '0;
        sel_a    = '0;
        sel_b    = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gsel == IW'(i)) begin
                sel_mode = req_mode[2*i +: 2];
                sel_a    = req_a[32*i +: 32];
                sel_b    = req_b[32*i +: 32];
            end
        end
    end

    assign dz   = alu_mode == 2'd1 && alu_b == '0;
    assign tmo  = wd == WW'(TIMEOUT - 1);
    assign g_oh = N_REQ'(1) << g;

    always_comb begin
        state_nx = state == IDLE  ? (any ? ISSUE : IDLE) :
                   state == ISSUE ? (dz ? RESP : WAIT) :
                   state == WAIT  ? ((alu_ready || tmo) ? RESP : WAIT) : IDLE;
    end

    assign req_ack   = state == ISSUE ? g_oh : '0;
    assign rsp_valid = state == RESP ? g_oh : '0;
    assign rsp_err   = state == RESP && err;
    assign busy      = state != IDLE;
    assign alu_valid = state == ISSUE && !dz;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= '0;
            g        <= '0;
            alu_mode <= '0;
            alu_a    <= '0;
            alu_b    <= '0;
            wd       <= '0;
            rsp_data <= '0;
            err      <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == IDLE && any) begin
                g        <= gsel;
                ptr      <= gsel == IW'(N_REQ - 1) ? '0 : gsel + 1'b1;
                alu_mode <= sel_mode;
                alu_a    <= sel_a;
                alu_b    <= sel_b;
            end
            if (state == ISSUE) begin
                wd <= '0;
                if (dz) begin
                    rsp_data <= '1;
                    err      <= 1'b1;
                end
            end
            // Ready takes priority over a coinciding watchdog expiry.
            if (state == WAIT) begin
                wd <= wd + 1'b1;
                if (alu_ready) begin
                    rsp_data <= alu_out;
                    err      <= 1'b0;
                end else if (tmo) begin
                    rsp_data <= '0;
                    err      <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_alu_sched.sv
// tb_alu_sched: directed test of alu_sched against a transaction-level model,
// with a behavioural ALU whose latency matches the specified cycle timing.
module tb_alu_sched;
    localparam int N  = 4;
    localparam int TO = 40;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req_valid;
    logic [2*N-1:0]  req_mode;
    logic [32*N-1:0] req_a, req_b;
    logic [N-1:0]    req_ack, rsp_valid;
    logic [63:0]     rsp_data;
    logic            rsp_err, busy, alu_valid;
    logic [1:0]      alu_mode;
    logic [31:0]     alu_a, alu_b;
    logic            alu_ready;
    logic [63:0]     alu_out;

    logic        hang = 1'b0, spur = 1'b0;
    logic        stub_ready, pend;
    int          rem;
    logic [1:0]  sm;
    logic [31:0] sa, sb;

    logic [1:0]  smode [N];
    logic [31:0] sa_arr [N], sb_arr [N];
    int          iss [N], ackc [N];

    int          cyc = 0;
    logic        m_busy = 1'b0, m_dz = 1'b0, m_err = 1'b0;
    int          m_g = 0, m_ack_at = -1, m_rsp_at = -1, m_ptr = 0;
    logic [63:0] m_res = '0, m_data = '0;

    int          last_ack_cyc, last_rsp_cyc, nrsp = 0, t0, n0;
    logic [63:0] last_data;
    logic        last_err, saw_alu_v;
    int          grant_log[$];
    int          checks = 0, errors = 0;
    int          rr_exp [5] = '{0, 1, 2, 3, 0};

    always #5 clk = ~clk;

    alu_sched #(.N_REQ(N), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_mode(req_mode),
        .req_a(req_a), .req_b(req_b), .req_ack(req_ack), .rsp_valid(rsp_valid),
        .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy), .alu_valid(alu_valid),
        .alu_mode(alu_mode), .alu_a(alu_a), .alu_b(alu_b), .alu_ready(alu_ready),
        .alu_out(alu_out)
    );

    function automatic logic [63:0] f(input logic [1:0] m, input logic [31:0] a, input logic [31:0] b);
        case (m)
            2'd0:    return {32'd0, a} * {32'd0, b};
            2'd1:    return b == 0 ? 64'd0 : {a % b, a / b};
            2'd2:    return {32'd0, a >> b[4:0]};
            default: return {31'd0, ({1'b0, a} + {1'b0, b}) >> 1};
        endcase
    endfunction

    function automatic int idx_of(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    always_comb begin
        for (int i = 0; i < N; i++) begin
            req_mode[2*i +: 2] = smode[i];
            req_a[32*i +: 32]  = sa_arr[i];
            req_b[32*i +: 32]  = sb_arr[i];
            req_valid[i]       = iss[i] != ackc[i];
        end
    end

    // ALU: ready two cycles after start for shift/avg, 33 for mulu/divu.
    assign alu_out   = f(sm, sa, sb);
    assign alu_ready = stub_ready | spur;
    always @(posedge clk) begin
        if (rst) begin
            pend       <= 1'b0;
            stub_ready <= 1'b0;
            rem        <= 0;
        end else begin
            stub_ready <= 1'b0;
            if (alu_valid && !hang) begin
                pend <= 1'b1;
                rem  <= alu_mode[1] ? 1 : 32;
                sm   <= alu_mode;
                sa   <= alu_a;
                sb   <= alu_b;
            end else if (pend) begin
                if (rem == 1) begin
                    pend       <= 1'b0;
                    stub_ready <= 1'b1;
                end
                rem <= rem - 1;
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endtask

    task automatic model_step();
        int c, lat;
        c = cyc;
        if (rst) begin
            m_busy = 1'b0;
            m_ptr  = 0;
            m_data = '0;
        end else if (m_busy) begin
            if (c == m_rsp_at) m_busy = 1'b0;
            else if (c + 1 == m_rsp_at) m_data = m_res;
        end else if (req_valid != '0) begin
            for (int k = 0; k < N; k++) begin
                int jj;
                jj = (m_ptr + k) % N;
                if (req_valid[jj]) begin
                    m_g      = jj;
                    m_ptr    = (jj + 1) % N;
                    m_busy   = 1'b1;
                    m_ack_at = c + 1;
                    m_dz     = smode[jj] == 2'd1 && sb_arr[jj] == 0;
                    if (m_dz) begin
                        lat = 1; m_res = '1; m_err = 1'b1;
                    end else if (hang) begin
                        lat = 1 + TO; m_res = '0; m_err = 1'b1;
                    end else begin
                        lat = smode[jj][1] ? 3 : 34;
                        m_res = f(smode[jj], sa_arr[jj], sb_arr[jj]);
                        m_err = 1'b0;
                    end
                    m_rsp_at = c + 1 + lat;
                    break;
                end
            end
        end
    endtask

    task automatic compare();
        logic [N-1:0] e_ack, e_rsp;
        e_ack = (m_busy && cyc == m_ack_at) ? N'(1) << m_g : '0;
        e_rsp = (m_busy && cyc == m_rsp_at) ? N'(1) << m_g : '0;
        chk("req_ack", req_ack, e_ack);
        chk("rsp_valid", rsp_valid, e_rsp);
        chk("busy", busy, m_busy);
        chk("alu_valid", alu_valid, e_ack != '0 && !m_dz);
        chk("rsp_data", rsp_data, m_data);
        if (e_rsp != '0) chk("rsp_err", rsp_err, m_err);
        if (req_ack != '0) begin
            grant_log.push_back(idx_of(req_ack));
            last_ack_cyc = cyc;
            for (int i = 0; i < N; i++) if (req_ack[i]) ackc[i]++;
        end
        if (rsp_valid != '0) begin
            nrsp++;
            last_rsp_cyc = cyc;
            last_data    = rsp_data;
            last_err     = rsp_err;
        end
        if (alu_valid) saw_alu_v = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        cyc++;
        @(negedge clk);
        compare();
    endtask

    task automatic start(input int i, input logic [1:0] m, input logic [31:0] a, input logic [31:0] b);
        smode[i]  = m;
        sa_arr[i] = a;
        sb_arr[i] = b;
        iss[i]++;
        t0 = cyc;
    endtask

    task automatic wait_n(input int n, input int budget);
        int base;
        base = nrsp;
        for (int k = 0; k < budget && nrsp - base < n; k++) tick();
        chk("rsp_count", 64'(nrsp - base), 64'(n));
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            smode[i] = '0; sa_arr[i] = '0; sb_arr[i] = '0; iss[i] = 0; ackc[i] = 0;
        end
        repeat (3) tick();
        chk("rst_busy", busy, 0);
        chk("rst_alu_mode", alu_mode, 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_b", alu_b, 0);
        chk("rst_rsp_err", rsp_err, 0);
        rst = 1'b0;
        tick();

        start(0, 2'd2, 32'h0000_00F0, 32'd3);
        wait_n(1, 10);
        chk("shift_ack_lat", 64'(last_ack_cyc - t0), 1);
        chk("shift_rsp_lat", 64'(last_rsp_cyc - t0), 4);
        chk("shift_data", last_data, 64'h1E);
        chk("shift_err", last_err, 0);
        tick();

        start(1, 2'd0, 32'hFFFF_FFFF, 32'd2);
        wait_n(1, 50);
        chk("mul_rsp_lat", 64'(last_rsp_cyc - t0), 35);
        chk("mul_data", last_data, 64'h1_FFFF_FFFE);
        tick();

        start(2, 2'd1, 32'd100, 32'd7);
        wait_n(1, 50);
        chk("div_rsp_lat", 64'(last_rsp_cyc - t0), 35);
        chk("div_data", last_data, 64'h0000_0002_0000_000E);
        tick();

        saw_alu_v = 1'b0;
        start(3, 2'd1, 32'd7, 32'd0);
        wait_n(1, 10);
        chk("dz_rsp_lat", 64'(last_rsp_cyc - t0), 2);
        chk("dz_err", last_err, 1);
        chk("dz_data", last_data, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("dz_no_alu_valid", saw_alu_v, 0);

        tick();
        spur = 1'b1;
        tick();
        spur = 1'b0;
        tick();
        chk("spur_busy", busy, 0);
        chk("spur_data", rsp_data, 64'hFFFF_FFFF_FFFF_FFFF);

        hang = 1'b1;
        start(2, 2'd0, 32'd5, 32'd6);
        wait_n(1, 60);
        chk("tmo_rsp_lat", 64'(last_rsp_cyc - t0), 2 + TO);
        chk("tmo_err", last_err, 1);
        chk("tmo_data", last_data, 0);
        tick();
        chk("tmo_busy_after", busy, 0);
        hang = 1'b0;

        rst = 1'b1;
        tick();
        rst = 1'b0;
        grant_log.delete();
        for (int i = 0; i < N; i++) start(i, 2'd3, 32'(i * 16 + 8), 32'd5);
        iss[0]++;
        wait_n(5, 60);
        chk("rr_cnt", 64'(grant_log.size()), 5);
        for (int k = 0; k < 5 && k < grant_log.size(); k++) chk("rr_order", 64'(grant_log[k]), 64'(rr_exp[k]));
        chk("rr_avg_data", last_data, 64'd6);
        tick();

        rst = 1'b1;
        tick();
        rst = 1'b0;
        grant_log.delete();
        start(2, 2'd2, 32'h100, 32'd4);
        start(0, 2'd2, 32'h100, 32'd8);
        wait_n(2, 20);
        chk("rst_rr_cnt", 64'(grant_log.size()), 2);
        if (grant_log.size() == 2) begin
            chk("rst_rr_first", 64'(grant_log[0]), 0);
            chk("rst_rr_second", 64'(grant_log[1]), 2);
        end
        tick();

        start(2, 2'd1, 32'd1000, 32'd3);
        repeat (10) tick();
        rst = 1'b1;
        n0 = nrsp;
        tick();
        rst = 1'b0;
        chk("mid_busy", busy, 0);
        chk("mid_ack", req_ack, 0);
        chk("mid_rsp_valid", rsp_valid, 0);
        chk("mid_alu_valid", alu_valid, 0);
        chk("mid_data", rsp_data, 0);
        chk("mid_alu_a", alu_a, 0);
        repeat (40) tick();
        chk("mid_no_rsp", 64'(nrsp - n0), 0);
        grant_log.delete();
        start(3, 2'd2, 32'h80, 32'd1);
        start(1, 2'd3, 32'd9, 32'd3);
        wait_n(2, 20);
        if (grant_log.size() == 2) begin
            chk("mid_next_first", 64'(grant_log[0]), 1);
            chk("mid_next_second", 64'(grant_log[1]), 3);
        end else chk("mid_next_cnt", 64'(grant_log.size()), 2);
        chk("mid_next_data", last_data, 64'h40);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout cyc=%0d", cyc);
        $fatal(1, "simulation did not finish");
    end
endmodule

// File: doc/alu_sched.md
# alu_sched

Round-robin scheduler that shares one multi-cycle ALU (mulu/divu/shift/avg, valid/ready, 64-bit result) among N_REQ requesters. It sits between requesting clients and the ALU, with at most one operation in flight. It issues the ALU start pulse, waits for the ALU's one-cycle ready pulse, and routes the 64-bit result back to the owning requester. Divide-by-zero is rejected locally, and a hung ALU is caught by a watchdog.

## Interface
- N_REQ, 4, number of requesters (2..8).
- TIMEOUT, 40, WAIT-state cycle limit before an error response (must exceed 34).
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  N_REQ  request pending per requester; held until acknowledged.
- req_mode  in  2*N_REQ  per-requester opcode: 0 mulu, 1 divu, 2 shift, 3 avg.
- req_a / req_b  in  32*N_REQ each  per-requester operands.
- req_ack  out  N_REQ  one-cycle one-hot pulse: operands captured.
- rsp_valid  out  N_REQ  one-cycle one-hot pulse: rsp_data/rsp_err valid for that requester.
- rsp_data  out  64  result; held until the next response.
- rsp_err  out  1  qualifies rsp_valid: 1 = divide-by-zero or timeout.
- busy  out  1  high in every state except IDLE.
- alu_valid  out  1  ALU start pulse.
- alu_mode  out  2  to the ALU.
- alu_a / alu_b  out  32 each  to the ALU.
- alu_ready  in  1  ALU completion pulse.
- alu_out  in  64  ALU result, valid when alu_ready=1.

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE
  - If any req_valid is set, grant g = first set bit scanning upward from ptr (circular).
  - Latch g, mode, a and b; set ptr <= (g+1) mod N_REQ; go to ISSUE.
- ISSUE
  - req_ack[g]=1.
  - If mode==1 and b==0: alu_valid=0, rsp_data <= 64'hFFFF_FFFF_FFFF_FFFF, err <= 1, go to RESP.
  - Otherwise: alu_valid=1, alu_mode/a/b driven from the latched values, clear the watchdog, go to WAIT.
- WAIT
  - Watchdog increments each cycle.
  - alu_ready=1: rsp_data <= alu_out, err <= 0, go to RESP.
  - Watchdog reaches TIMEOUT with no ready: rsp_data <= 0, err <= 1, go to RESP.
  - If ready and timeout coincide, ready wins.
- RESP: rsp_valid[g]=1, rsp_err=err, go to IDLE.
- alu_ready outside WAIT is ignored.
- alu_mode/alu_a/alu_b hold their latched values at all times; they are 0 after reset.
- A requester must not change operands while req_valid=1 and before req_ack.
- Deasserting req_valid before ack withdraws the request, but only if it has not yet been granted. After grant, the operation completes regardless.
- Reset mid-operation: state returns to IDLE and the in-flight result is discarded (no rsp_valid). The top level ties the ALU's rst_n = ~rst, so both reset together.

## Timing
- Reset values: state IDLE, ptr 0, all outputs 0, rsp_data 0, alu_* 0.
- Request seen in IDLE at cycle 0:
  - ISSUE/req_ack at cycle 1.
  - shift/avg: alu_ready at cycle 3, rsp_valid at cycle 4.
  - mulu/divu: alu_ready at cycle 34, rsp_valid at cycle 35.
  - divide-by-zero: rsp_valid at cycle 2.
  - timeout: rsp_valid at cycle 2+TIMEOUT.
- Back-to-back: the next grant decision is in the IDLE cycle after RESP. The ALU has returned to IDLE by the next ISSUE, so no overlap occurs.
- Throughput: one operation per 5 cycles (shift/avg) or 36 cycles (mulu/divu).

## Test plan
- Single shift: req0 mode=2, a=0x0000_00F0, b=3 -> req_ack[0] at cycle 1, rsp_valid[0] at cycle 4, rsp_data=0x1E, rsp_err=0.
- Multiply latency: req1 mode=0, a=0xFFFF_FFFF, b=2 -> rsp_valid[1] at cycle 35, rsp_data=0x1_FFFF_FFFE.
- Round-robin: req0..req3 all held valid with avg ops -> grants in order 0,1,2,3,0. After reset, with only req2 and req0 valid, grant order is 0 then 2.
- Divide-by-zero: req3 mode=1, a=7, b=0 -> alu_valid never asserts, rsp_valid[3] at cycle 2, rsp_err=1, rsp_data=all ones.
- Timeout: ALU model never asserts ready, mode=0 -> rsp_valid at cycle 42, rsp_err=1, rsp_data=0, then busy=0.
- Reset mid-op: rst pulse at cycle 10 of a divu -> no rsp_valid, busy=0 and all outputs 0 the cycle after, next request serviced normally from ptr=0.
